load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Memory-access stage directly downstream of the ALU. Takes alu_result as the effective address,
//  plus rs2 store data and funct3 size code. Runs one load/store per request over a req/ack
//  data-memory port. Returns an aligned, sign/zero-extended load result or store completion.
//  Flags misaligned or illegal accesses without touching memory.
// PARAMETERS
//  OPERAND_LENGTH  32  datapath width; only 32 is supported (byte lanes fixed at 4)
//  REG_ADDR_LENGTH  5  destination register index width, passed through
// PORTS
//  clk            in   1   clock, rising edge
//  rst            in   1   reset, asynchronous, active-high
//  req_valid      in   1   request present
//  req_ready      out  1   LSU can accept; 1 only in IDLE
//  req_is_store   in   1   1=store, 0=load
//  req_funct3     in   3   000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only)
//  req_addr       in   32  effective address (alu_result)
//  req_wdata      in   32  store data (rs2)
//  req_rd         in   5   load destination register
//  mem_req        out  1   memory request; held until mem_ack
//  mem_we         out  1   1=write
//  mem_addr       out  32  word address {req_addr[31:2],2'b00}
//  mem_wdata      out  32  store data replicated into its lane(s)
//  mem_be         out  4   byte enables; 4'b0000 on reads
//  mem_ack        in   1   memory done; mem_rdata valid this cycle
//  mem_rdata      in   32  read word
//  rsp_valid      out  1   one-cycle pulse: result ready
//  rsp_data       out  32  extended load data; 0 for stores and errors
//  rsp_rd         out  5   echoed req_rd
//  rsp_misaligned out  1   H/HU with addr[0]!=0, or W with addr[1:0]!=0
//  rsp_illegal    out  1   funct3 in {011,110,111}, or store with funct3 100/101
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0 except req_ready=1. Reset mid-access drops mem_req at once.
//    Any pending ack is ignored. No rsp is produced for the aborted op.
//  - FSM: IDLE -> (accept & legal & aligned) ACCESS; IDLE -> (accept & error) RESP;
//    ACCESS -> (mem_ack) RESP; RESP -> IDLE. Accept = req_valid & req_ready.
//  - On accept, register the request fields. Next cycle in ACCESS: mem_req=1 with registered
//    mem_we/addr/be/wdata, held stable until mem_ack.
//  - mem_ack is sampled only while mem_req=1; an ack in the first ACCESS cycle is valid.
//  - Load data is captured on ack. In RESP: rsp_valid=1 for one cycle, rsp_* registered.
//  - Latency: accept T, mem_req T+1, earliest ack T+1, rsp_valid T+2. Error path: rsp_valid T+1.
//  - Throughput: one op per 3 cycles minimum; req_ready=0 in ACCESS and RESP.
//  - Store lanes: B -> be=1<<addr[1:0], wdata={4{b}}. H -> be=addr[1]?1100:0011, wdata={2{h}}.
//    W -> be=1111.
//  - Load extract: byte at addr[1:0] or half at addr[1]. B/H sign-extend; BU/HU zero-extend.
//  - Misaligned and illegal both set: report both flags, no memory access.
//  - req_* inputs are ignored outside IDLE.
// STRUCTURE
//  - Shared include lsu_defs.v: funct3 codes (LSU_B/H/W/BU/HU), FSM state encodings.
//    These are also used by the decoder.
//  - Sub-module load_extender: combinational (rdata, addr[1:0], funct3) -> 32b extended result.
//  - Top holds the FSM, request registers, lane/byte-enable generation and the response register.
// TESTING
//  1 LW addr 0x100, ack T+1, rdata 0xDEADBEEF -> mem_addr 0x100, be 0000, rsp T+2 = 0xDEADBEEF.
//  2 LB addr 0x103, rdata 0x80FF_0000 -> rsp 0xFFFFFF80. LBU same -> 0x00000080.
//    LHU addr 0x102 -> 0x000080FF.
//  3 SH addr 0x206, wdata 0x1234ABCD -> mem_we 1, addr 0x204, be 1100, wdata 0xABCDABCD, rsp_data 0.
//  4 LW addr 0x101 -> no mem_req, rsp_valid at T+1, rsp_misaligned 1.
//    SB funct3 100 -> rsp_illegal 1.
//  5 mem_ack delayed 5 cycles -> mem_req/addr/be stable throughout, req_ready 0, single rsp pulse.
//  6 rst pulsed while mem_req=1 -> mem_req 0 same cycle, no rsp_valid.
//    Next LW after release completes normally.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: funct3 size codes, FSM encodings,
// the registered memory-operation record and small decode helpers.
// The funct3 codes and state encodings are also used by the instruction decoder.
package load_store_unit_pkg;

  // funct3 size codes (BU/HU are load-only)
  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  // Request as it is driven onto the memory port, plus what the load path needs.
  typedef struct packed {
    logic        we;
    logic [31:0] addr;    // word-aligned
    logic [3:0]  be;
    logic [31:0] wdata;   // lane-replicated
    logic [2:0]  funct3;
    logic [1:0]  lane;    // original addr[1:0]
  } mem_op_t;

  function automatic logic is_illegal(input logic is_store, input logic [2:0] f3);
    case (f3)
      LSU_B, LSU_H, LSU_W: is_illegal = 1'b0;
      LSU_BU, LSU_HU:      is_illegal = is_store;
      default:             is_illegal = 1'b1;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      LSU_H, LSU_HU: is_misaligned = a[0];
      LSU_W:         is_misaligned = (a != 2'b00);
      default:       is_misaligned = 1'b0;
    endcase
  endfunction

  // Only called for legal, aligned stores.
  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      LSU_B:   store_be = 4'b0001 << a;
      LSU_H:   store_be = a[1] ? 4'b1100 : 4'b0011;
      default: store_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      LSU_B:   store_data = {4{d[7:0]}};
      LSU_H:   store_data = {2{d[15:0]}};
      default: store_data = d;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_load_extender.sv
// Purpose: pick the addressed byte/half out of a read word and sign/zero-extend it.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
// Ports: rdata (read word), lane (addr[1:0]), funct3 (size code) -> data (extended result).
module load_extender
  import load_store_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (lane)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = lane[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    data = 32'h0;
    case (funct3)
      LSU_B:   data = {{24{byte_sel[7]}}, byte_sel};
      LSU_H:   data = {{16{half_sel[15]}}, half_sel};
      LSU_W:   data = rdata;
      LSU_BU:  data = {24'h0, byte_sel};
      LSU_HU:  data = {16'h0, half_sel};
      default: data = 32'h0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Purpose: memory-access stage; one load/store per request over a req/ack data-memory port.
// Latency: accept T -> mem_req T+1 -> rsp_valid one cycle after mem_ack; errors respond at T+1.
// Backpressure: req_ready only in IDLE; mem_req and its fields are held until mem_ack.
// Ports: req_* (request from ALU stage), mem_* (data-memory port), rsp_* (one-cycle result pulse
//        with extended load data, echoed rd, misaligned/illegal flags).
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int OPERAND_LENGTH  = 32,
  parameter int REG_ADDR_LENGTH = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_is_store,
  input  logic [2:0]                 req_funct3,
  input  logic [OPERAND_LENGTH-1:0]  req_addr,
  input  logic [OPERAND_LENGTH-1:0]  req_wdata,
  input  logic [REG_ADDR_LENGTH-1:0] req_rd,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [OPERAND_LENGTH-1:0]  mem_addr,
  output logic [OPERAND_LENGTH-1:0]  mem_wdata,
  output logic [3:0]                 mem_be,
  input  logic                       mem_ack,
  input  logic [OPERAND_LENGTH-1:0]  mem_rdata,
  output logic                       rsp_valid,
  output logic [OPERAND_LENGTH-1:0]  rsp_data,
  output logic [REG_ADDR_LENGTH-1:0] rsp_rd,
  output logic                       rsp_misaligned,
  output logic                       rsp_illegal
);

  logic [1:0]                 state;
  mem_op_t                    op_q;
  logic [REG_ADDR_LENGTH-1:0] rd_q;

  logic        accept;
  logic        req_mis;
  logic        req_ill;
  logic [31:0] load_data;

  assign req_ready = (state == ST_IDLE);
  assign accept    = req_valid & req_ready;
  assign req_mis   = is_misaligned(req_funct3, req_addr[1:0]);
  assign req_ill   = is_illegal(req_is_store, req_funct3);

  // Decoded straight from state so an async reset drops the request immediately.
  assign mem_req   = (state == ST_ACCESS);
  assign mem_we    = op_q.we;
  assign mem_addr  = op_q.addr;
  assign mem_wdata = op_q.wdata;
  assign mem_be    = op_q.be;

  load_extender u_load_extender (
    .rdata  (mem_rdata),
    .lane   (op_q.lane),
    .funct3 (op_q.funct3),
    .data   (load_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      op_q           <= '0;
      rd_q           <= '0;
      rsp_valid      <= 1'b0;
      rsp_data       <= '0;
      rsp_rd         <= '0;
      rsp_misaligned <= 1'b0;
      rsp_illegal    <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            rd_q <= req_rd;
            if (req_mis || req_ill) begin
              // Error path skips memory entirely; both flags may be set together.
              state          <= ST_RESP;
              rsp_valid      <= 1'b1;
              rsp_data       <= '0;
              rsp_rd         <= req_rd;
              rsp_misaligned <= req_mis;
              rsp_illegal    <= req_ill;
            end else begin
              state       <= ST_ACCESS;
              op_q.we     <= req_is_store;
              op_q.addr   <= {req_addr[31:2], 2'b00};
              op_q.be     <= req_is_store ? store_be(req_funct3, req_addr[1:0]) : 4'b0000;
              op_q.wdata  <= req_is_store ? store_data(req_funct3, req_wdata) : 32'h0;
              op_q.funct3 <= req_funct3;
              op_q.lane   <= req_addr[1:0];
            end
          end
        end
        ST_ACCESS: begin
          if (mem_ack) begin
            state          <= ST_RESP;
            rsp_valid      <= 1'b1;
            rsp_data       <= op_q.we ? 32'h0 : load_data;
            rsp_rd         <= rd_q;
            rsp_misaligned <= 1'b0;
            rsp_illegal    <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_is_store = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [4:0]  req_rd = 5'd0;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_rd;
  logic        rsp_misaligned;
  logic        rsp_illegal;

  load_store_unit dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_rd(rsp_rd),
    .rsp_misaligned(rsp_misaligned), .rsp_illegal(rsp_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        mis;
    logic        ill;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_ops    = 0;
  int   rsp_cnt  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Count every response pulse so stray or duplicate pulses show up.
  always @(negedge clk) if (rsp_valid === 1'b1) rsp_cnt++;

  task automatic do_op(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [4:0] rd, input logic [31:0] rdata,
                       input int delay, input logic exp_mem, input logic [3:0] exp_be,
                       input logic [31:0] exp_wdata, input logic [31:0] exp_data,
                       input logic exp_mis, input logic exp_ill);
    exp_t e;
    exp_t g;
    @(negedge clk);
    check("req_ready_idle", {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3;
    req_addr = addr; req_wdata = wdata; req_rd = rd;
    @(negedge clk);
    // Garbage on the request bus outside IDLE must be ignored.
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
    req_funct3 = 3'($urandom_range(0, 7)); req_rd = 5'($urandom);
    e.data = exp_data; e.rd = rd; e.mis = exp_mis; e.ill = exp_ill;
    sb_q.push_back(e);
    n_ops++;
    if (exp_mem) begin
      for (int i = 0; i <= delay; i++) begin
        check("mem_req", {31'h0, mem_req}, 32'h1);
        check("mem_we", {31'h0, mem_we}, {31'h0, st});
        check("mem_addr", mem_addr, {addr[31:2], 2'b00});
        check("mem_be", {28'h0, mem_be}, {28'h0, exp_be});
        if (st) check("mem_wdata", mem_wdata, exp_wdata);
        check("req_ready_busy", {31'h0, req_ready}, 32'h0);
        check("rsp_early", {31'h0, rsp_valid}, 32'h0);
        if (i < delay) @(negedge clk);
      end
      mem_ack = 1'b1; mem_rdata = rdata;
      @(negedge clk);
      mem_ack = 1'b0; mem_rdata = $urandom;
    end else begin
      check("no_mem_req", {31'h0, mem_req}, 32'h0);
    end
    check("rsp_valid", {31'h0, rsp_valid}, 32'h1);
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'h1, 32'h0);
    end else begin
      g = sb_q.pop_front();
      check("rsp_data", rsp_data, g.data);
      check("rsp_rd", {27'h0, rsp_rd}, {27'h0, g.rd});
      check("rsp_mis", {31'h0, rsp_misaligned}, {31'h0, g.mis});
      check("rsp_ill", {31'h0, rsp_illegal}, {31'h0, g.ill});
    end
    @(negedge clk);
    check("rsp_single", {31'h0, rsp_valid}, 32'h0);
    check("ready_after", {31'h0, req_ready}, 32'h1);
  endtask

  localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010, F_BU = 3'b100, F_HU = 3'b101;

  int cnt_before;

  initial begin
    repeat (2) @(negedge clk);
    check("rst_ready", {31'h0, req_ready}, 32'h1);
    check("rst_mem_req", {31'h0, mem_req}, 32'h0);
    check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("rst_mem_be", {28'h0, mem_be}, 32'h0);
    check("rst_rsp_data", rsp_data, 32'h0);
    rst = 1'b0;

    // Loads
    do_op(0, F_W,  32'h100, 0, 5'd1, 32'hDEADBEEF, 0, 1, 4'b0000, 0, 32'hDEADBEEF, 0, 0);
    do_op(0, F_B,  32'h103, 0, 5'd2, 32'h80FF0000, 0, 1, 4'b0000, 0, 32'hFFFFFF80, 0, 0);
    do_op(0, F_BU, 32'h103, 0, 5'd3, 32'h80FF0000, 0, 1, 4'b0000, 0, 32'h00000080, 0, 0);
    do_op(0, F_HU, 32'h102, 0, 5'd4, 32'h80FF0000, 1, 1, 4'b0000, 0, 32'h000080FF, 0, 0);
    do_op(0, F_H,  32'h102, 0, 5'd5, 32'h80FF0000, 0, 1, 4'b0000, 0, 32'hFFFF80FF, 0, 0);
    do_op(0, F_B,  32'h102, 0, 5'd6, 32'h80FF0000, 0, 1, 4'b0000, 0, 32'hFFFFFFFF, 0, 0);
    do_op(0, F_H,  32'h100, 0, 5'd7, 32'h12347FFE, 0, 1, 4'b0000, 0, 32'h00007FFE, 0, 0);
    // Stores
    do_op(1, F_H, 32'h206, 32'h1234ABCD, 5'd8, 32'h0, 0, 1, 4'b1100, 32'hABCDABCD, 0, 0, 0);
    do_op(1, F_B, 32'h201, 32'h000000EF, 5'd9, 32'h0, 2, 1, 4'b0010, 32'hEFEFEFEF, 0, 0, 0);
    do_op(1, F_W, 32'h208, 32'hCAFEF00D, 5'd10, 32'h0, 0, 1, 4'b1111, 32'hCAFEF00D, 0, 0, 0);
    // Errors: no memory access, response one cycle after accept
    do_op(0, F_W,   32'h101, 0, 5'd11, 0, 0, 0, 0, 0, 0, 1, 0);
    do_op(1, F_BU,  32'h200, 0, 5'd12, 0, 0, 0, 0, 0, 0, 0, 1);
    do_op(1, F_HU,  32'h203, 0, 5'd13, 0, 0, 0, 0, 0, 0, 1, 1);
    do_op(0, 3'b011, 32'h200, 0, 5'd14, 0, 0, 0, 0, 0, 0, 0, 1);
    // Long ack delay: request must stay stable throughout
    do_op(0, F_W, 32'h40C, 0, 5'd15, 32'h0BADF00D, 5, 1, 4'b0000, 0, 32'h0BADF00D, 0, 0);

    // Reset during an access: request drops at once, pending ack is ignored, no response.
    @(negedge clk);
    cnt_before = rsp_cnt;
    req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = F_W; req_addr = 32'h300; req_rd = 5'd16;
    @(negedge clk);
    req_valid = 1'b0;
    check("abort_mem_req_before", {31'h0, mem_req}, 32'h1);
    rst = 1'b1;
    #1;
    check("abort_mem_req_drop", {31'h0, mem_req}, 32'h0);
    check("abort_ready", {31'h0, req_ready}, 32'h1);
    mem_ack = 1'b1; mem_rdata = 32'h55555555;
    @(negedge clk);
    mem_ack = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_no_rsp", rsp_cnt, cnt_before);
    check("abort_idle_mem_req", {31'h0, mem_req}, 32'h0);

    do_op(0, F_W, 32'h300, 0, 5'd17, 32'h13579BDF, 0, 1, 4'b0000, 0, 32'h13579BDF, 0, 0);

    repeat (3) @(negedge clk);
    check("rsp_pulse_total", rsp_cnt, n_ops);
    check("sb_drained", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
